// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the async-serial receive path: state encodings, frame size
// and the bit-period derivation used by both receiver and (future) transmitter.
package uart_rx_byte_pkg;

    localparam int FRAME_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    // Truncating divide: clk cycles per line bit.
    function automatic int cyc_count(input int sys_clk, input int baud);
        return sys_clk / baud;
    endfunction

    function automatic int half_count(input int cyc);
        return cyc / 2;
    endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Serial-in / parallel-out bundle between the line side and the byte consumer.
interface uart_rx_byte_if;
    import uart_rx_byte_pkg::*;

    logic                  din;
    logic [FRAME_BITS-1:0] data;
    logic                  valid;
    logic                  frame_err;
    logic                  busy;

    modport master (output din, input  data, valid, frame_err, busy);
    modport slave  (input  din, output data, valid, frame_err, busy);

endinterface

// File: rtl/uart_rx_byte_sync.sv
// Two-flop synchroniser; RST_VAL lets the line side reset to its idle level.
module uart_rx_byte_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: finds the start-bit centre, then samples every following bit one
// bit period later, emitting a one-cycle valid or frame_err per frame.
module uart_rx_byte import uart_rx_byte_pkg::*; #(
    parameter int SYSTEM_CLOCK = 32000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CYC_COUNT    = cyc_count(SYSTEM_CLOCK, BAUD_RATE),
    parameter int HALF_COUNT   = half_count(CYC_COUNT),
    parameter int CNT_WIDTH    = $clog2(CYC_COUNT)
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_byte_if.slave  bus
);

    logic                  w_din_s;
    state_e                r_state;
    state_e                w_next;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [2:0]            r_bit_idx;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  w_half_hit;
    logic                  w_bit_hit;
    logic                  w_sample;
    logic                  w_done_ok;
    logic                  w_done_err;
    logic                  w_busy;

    uart_rx_byte_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.din),
        .o_q   (w_din_s)
    );

    assign w_half_hit = (r_cnt == CNT_WIDTH'(HALF_COUNT - 1));
    assign w_bit_hit  = (r_cnt == CNT_WIDTH'(CYC_COUNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (!w_din_s) w_next = ST_START;
            ST_START: if (w_half_hit) w_next = w_din_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_bit_hit && r_bit_idx == 3'(FRAME_BITS - 1)) w_next = ST_STOP;
            ST_STOP:  if (w_bit_hit) w_next = w_din_s ? ST_IDLE : ST_BREAK;
            // A held-low line must return high before a new start is accepted.
            ST_BREAK: if (w_din_s) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sample   = (r_state == ST_DATA) && w_bit_hit;
        w_done_ok  = (r_state == ST_STOP) && w_bit_hit &&  w_din_s;
        w_done_err = (r_state == ST_STOP) && w_bit_hit && !w_din_s;
        w_busy     = (r_state != ST_IDLE);
    end

    // Counter restarts on every state change and wraps per bit inside DATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_next != r_state || r_state == ST_IDLE || r_state == ST_BREAK)
                r_cnt <= '0;
            else if (w_bit_hit)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_state != ST_DATA) r_bit_idx <= '0;
            else if (w_sample)      r_bit_idx <= r_bit_idx + 3'd1;

            if (w_sample) r_shift <= {w_din_s, r_shift[FRAME_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= w_done_ok;
            r_ferr  <= w_done_err;
            if (w_done_ok) r_data <= r_shift;
        end
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = w_busy;

endmodule
